// File: rtl/cfb_d_stream.sv
// cfb_d_stream: streaming AES-128 CFB-128 decryptor.
// Each block is decrypted as P = C ^ AES_K(fb), and then fb becomes C.
// The keystream is registered in a one-cycle GEN state, so the combinational
// cipher path ends at ks_r and never reaches the plaintext output.
//
// state | meaning
// IDLE  | no stream active; waits for start (the output may still be draining)
// GEN   | ks_r <= AES(key_r, fb_r)
// WAIT  | keystream ready; accepts one ciphertext block when the output slot is free
module cfb_d_stream #(
  parameter int NUM_BLOCKS = 65536,
  parameter int CNT_W      = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [128:1]     key,
  input  logic [128:1]     iv,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [128:1]     ciphertext,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [128:1]     plaintext,
  output logic [CNT_W:1]   blk_cnt,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {S_IDLE, S_GEN, S_WAIT} state_t;

  localparam logic [CNT_W:1] LAST = CNT_W'(NUM_BLOCKS);
  localparam logic [CNT_W:1] ONE  = CNT_W'(1);

  state_t         state, state_nxt;
  logic [128:1]   key_r, fb_r, ks_r, pt_r;
  logic           out_valid_r;
  logic [CNT_W:1] blk_cnt_r, cnt_inc;
  logic           in_ready_c, accept, done_c;
  logic [127:0]   aes_out;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box: the inverse is x^254 (squarings x^2..x^128 multiplied together), then the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq, r;
    sq = x;
    r  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    return {sub_word(s[127:96]), sub_word(s[95:64]), sub_word(s[63:32]), sub_word(s[31:0])};
  endfunction

  // Byte i sits at bits [127-8i -: 8]; row r, column c is byte r+4c.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rcon);
    logic [31:0] t, n0, n1, n2, n3;
    t  = sub_word({k[23:0], k[31:24]}) ^ {rcon, 24'h000000};
    n0 = k[127:96] ^ t;
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  function automatic logic [127:0] aes_encrypt(input logic [127:0] k, input logic [127:0] blk);
    logic [127:0] rk, s;
    logic [7:0]   rcon;
    rk   = k;
    s    = blk ^ rk;
    rcon = 8'h01;
    for (int rd = 1; rd <= 10; rd++) begin
      rk   = next_key(rk, rcon);
      rcon = xtime(rcon);
      s    = shift_rows(sub_bytes(s));
      if (rd != 10) s = mix_columns(s);
      s    = s ^ rk;
    end
    return s;
  endfunction

  // Forward cipher on the registered feedback value; its only consumer is ks_r.
  always_comb aes_out = aes_encrypt(key_r, fb_r);

  assign cnt_inc = blk_cnt_r + ONE;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic, input handshake and the done pulse.
  always_comb begin
    state_nxt  = state;
    in_ready_c = 1'b0;
    accept     = 1'b0;
    done_c     = 1'b0;
    case (state)
      S_IDLE: if (start) state_nxt = S_GEN;
      S_GEN:  state_nxt = S_WAIT;
      S_WAIT: begin
        in_ready_c = !out_valid_r || out_ready;
        if (in_valid && in_ready_c) begin
          accept = 1'b1;
          if (cnt_inc == LAST) begin
            done_c    = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            state_nxt = S_GEN;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Key, feedback, keystream, plaintext and block counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_r     <= '0;
      fb_r      <= '0;
      ks_r      <= '0;
      pt_r      <= '0;
      blk_cnt_r <= '0;
    end else begin
      if (state == S_IDLE && start) begin
        key_r     <= key;
        fb_r      <= iv;
        blk_cnt_r <= '0;
      end
      if (state == S_GEN) ks_r <= aes_out;
      if (accept) begin
        pt_r      <= ciphertext ^ ks_r;
        fb_r      <= ciphertext;
        blk_cnt_r <= cnt_inc;
      end
    end
  end

  // Output slot: a load wins over a drain in the same cycle; this is independent of the FSM state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            out_valid_r <= 1'b0;
    else if (accept)    out_valid_r <= 1'b1;
    else if (out_ready) out_valid_r <= 1'b0;
  end

  assign in_ready  = in_ready_c;
  assign out_valid = out_valid_r;
  assign plaintext = pt_r;
  assign blk_cnt   = blk_cnt_r;
  assign busy      = (state != S_IDLE);
  assign done      = done_c;

endmodule

// File: tb/tb_cfb_d_stream.sv
// Bench for cfb_d_stream: an independent AES/CFB stream model, per-cycle compare, and directed NIST vectors.
module tb_cfb_d_stream;

  logic         clk, rst, start, in_valid, out_ready, sel;
  logic [128:1] key, iv, ciphertext;
  logic         start_a, start_b;

  logic         a_in_ready, a_out_valid, a_busy, a_done;
  logic [128:1] a_plaintext;
  logic [3:1]   a_blk_cnt;
  logic         b_in_ready, b_out_valid, b_busy, b_done;
  logic [128:1] b_plaintext;
  logic [5:1]   b_blk_cnt;

  assign start_a = start & ~sel;
  assign start_b = start & sel;

  cfb_d_stream #(.NUM_BLOCKS(4), .CNT_W(3)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .key(key), .iv(iv),
    .in_valid(in_valid), .in_ready(a_in_ready), .ciphertext(ciphertext),
    .out_valid(a_out_valid), .out_ready(out_ready), .plaintext(a_plaintext),
    .blk_cnt(a_blk_cnt), .busy(a_busy), .done(a_done));

  cfb_d_stream #(.NUM_BLOCKS(16), .CNT_W(5)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .key(key), .iv(iv),
    .in_valid(in_valid), .in_ready(b_in_ready), .ciphertext(ciphertext),
    .out_valid(b_out_valid), .out_ready(out_ready), .plaintext(b_plaintext),
    .blk_cnt(b_blk_cnt), .busy(b_busy), .done(b_done));

  logic         rdy_m, ov_m, busy_m, done_m;
  logic [127:0] pt_m;
  int           cnt_m, num_m;
  assign rdy_m  = sel ? b_in_ready  : a_in_ready;
  assign ov_m   = sel ? b_out_valid : a_out_valid;
  assign busy_m = sel ? b_busy      : a_busy;
  assign done_m = sel ? b_done      : a_done;
  assign pt_m   = sel ? b_plaintext : a_plaintext;
  assign cnt_m  = sel ? int'(b_blk_cnt) : int'(a_blk_cnt);
  assign num_m  = sel ? 16 : 4;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  // Independent cipher model: carry-less multiply with reduction, brute-force inverse S-box table.
  logic [7:0] sb [256];

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'h0;
    for (int i = 0; i < 8; i++) if (a[i]) p = p ^ (16'(b) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, s, c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sb[x] = s;
    end
  endtask

  function automatic logic [127:0] model_aes(input logic [127:0] k, input logic [127:0] blk);
    logic [31:0]  w [44];
    logic [31:0]  t;
    logic [7:0]   rc;
    logic [7:0]   st [4][4];
    logic [7:0]   tp [4][4];
    logic [7:0]   a [4];
    logic [127:0] o;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
        rc = gm(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        st[r][c] = blk[127-8*(r+4*c) -: 8] ^ w[c][31-8*r -: 8];
    for (int rd = 1; rd <= 10; rd++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) tp[r][c] = sb[st[(r)][(c+r)%4]];
      for (int c = 0; c < 4; c++) begin
        for (int r = 0; r < 4; r++) a[r] = tp[r][c];
        for (int r = 0; r < 4; r++)
          st[r][c] = ((rd < 10) ? (gm(8'h02, a[r]) ^ gm(8'h03, a[(r+1)%4]) ^ a[(r+2)%4] ^ a[(r+3)%4])
                                : a[r]) ^ w[4*rd+c][31-8*r -: 8];
      end
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) o[127-8*(r+4*c) -: 8] = st[r][c];
    return o;
  endfunction

  // Stream-level model of the selected instance.
  logic         m_active, m_gen, m_ov;
  logic [127:0] m_key, m_fb, m_pt;
  int           m_cnt, cyc, done_seen;
  logic [127:0] obs [$];
  int           acc_cyc [$];

  // Per-cycle compare against the model, then advance the model across the coming edge.
  always @(negedge clk) begin
    logic exp_rdy, acc;
    cyc++;
    if (rst) begin
      m_active = 0; m_gen = 0; m_ov = 0; m_key = '0; m_fb = '0; m_pt = '0; m_cnt = 0;
      chk("rst_in_ready", 128'(rdy_m), 128'(0));
      chk("rst_out_valid", 128'(ov_m), 128'(0));
      chk("rst_plaintext", pt_m, 128'(0));
      chk("rst_blk_cnt", 128'(cnt_m), 128'(0));
      chk("rst_busy", 128'(busy_m), 128'(0));
      chk("rst_done", 128'(done_m), 128'(0));
    end else begin
      exp_rdy = m_active && m_gen && (!m_ov || out_ready);
      acc     = exp_rdy && in_valid;
      chk("in_ready", 128'(rdy_m), 128'(exp_rdy));
      chk("out_valid", 128'(ov_m), 128'(m_ov));
      if (m_ov) chk("plaintext", pt_m, m_pt);
      chk("blk_cnt", 128'(cnt_m), 128'(m_cnt));
      chk("busy", 128'(busy_m), 128'(m_active));
      chk("done", 128'(done_m), 128'(acc && (m_cnt + 1 == num_m)));
      if (done_m) done_seen++;
      if (m_ov && out_ready) obs.push_back(pt_m);
      if (acc) acc_cyc.push_back(cyc);
      m_ov = acc ? 1'b1 : (out_ready ? 1'b0 : m_ov);
      if (start && !m_active) begin
        m_key = key; m_fb = iv; m_cnt = 0; m_active = 1; m_gen = 0;
      end else if (m_active && !m_gen) begin
        m_gen = 1;
      end else if (acc) begin
        m_pt  = ciphertext ^ model_aes(m_key, m_fb);
        m_fb  = ciphertext;
        m_cnt = m_cnt + 1;
        m_gen = 0;
        if (m_cnt == num_m) m_active = 0;
      end
    end
  end

  localparam logic [127:0] NK  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] NIV = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] AIV = 128'h04c723c31896059a071280e2eb27b275;
  logic [127:0] nc [4];
  logic [127:0] np [4];
  logic [127:0] rp [16];
  logic [127:0] rc [16];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_start(input logic [127:0] k, input logic [127:0] v);
    key = k; iv = v; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [127:0] c, input logic keep);
    logic got;
    got = 1'b0;
    in_valid = 1'b1; ciphertext = c;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (rdy_m) begin
        @(posedge clk); #1;
        got = 1'b1;
      end
    end
    chk("send_timeout", 128'(got), 128'(1));
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic wait_drained();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (!busy_m && !ov_m) ok = 1'b1;
    end
    chk("drain_timeout", 128'(ok), 128'(1));
  endtask

  task automatic check_nist(input string tag);
    chk({tag, "_count"}, 128'(obs.size()), 128'(4));
    for (int i = 0; i < 4 && i < obs.size(); i++) chk({tag, "_pt"}, obs[i], np[i]);
  endtask

  task automatic clear_obs();
    obs.delete(); acc_cyc.delete(); done_seen = 0;
  endtask

  initial begin
    logic [127:0] fb;
    nc[0] = 128'h3b3fd92eb72dad20333449f8e83cfb4a; np[0] = 128'h6bc1bee22e409f96e93d7e117393172a;
    nc[1] = 128'hc8a64537a0b3a93fcde3cdad9f1ce58b; np[1] = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    nc[2] = 128'h26751f67a3cbb140b1808cf187a4f4df; np[2] = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
    nc[3] = 128'hc04b05357c5d1c0eeac4c66f9ff7f2e6; np[3] = 128'hf69f2445df4f9b17ad2b417be66c3710;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1; sel = 1'b0;
    key = '0; iv = '0; ciphertext = '0;
    build_sbox();
    chk("model_sbox00", 128'(sb[0]), 128'(8'h63));
    chk("model_sbox53", 128'(sb[8'h53]), 128'(8'hed));
    chk("model_nist_blk1", model_aes(NK, NIV) ^ nc[0], np[0]);
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // NIST stream, free-running sink
    clear_obs();
    do_start(NK, NIV);
    for (int i = 0; i < 4; i++) send(nc[i], 1'b0);
    wait_drained();
    check_nist("nist");
    chk("nist_done_once", 128'(done_seen), 128'(1));
    chk("nist_blk_cnt", 128'(cnt_m), 128'(4));
    chk("nist_busy", 128'(busy_m), 128'(0));

    // Backpressure after block 1
    clear_obs();
    do_start(NK, NIV);
    send(nc[0], 1'b0);
    out_ready = 1'b0; in_valid = 1'b1; ciphertext = nc[1];
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_pt", pt_m, np[0]);
      chk("bp_in_ready", 128'(rdy_m), 128'(0));
      chk("bp_out_valid", 128'(ov_m), 128'(1));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = 1; i < 4; i++) send(nc[i], 1'b0);
    wait_drained();
    check_nist("bp");

    // Asynchronous reset after block 2, then restart
    clear_obs();
    do_start(NK, NIV);
    send(nc[0], 1'b0);
    send(nc[1], 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", 128'(ov_m), 128'(0));
    chk("arst_plaintext", pt_m, 128'(0));
    chk("arst_blk_cnt", 128'(cnt_m), 128'(0));
    chk("arst_busy", 128'(busy_m), 128'(0));
    chk("arst_in_ready", 128'(rdy_m), 128'(0));
    tick();
    rst = 1'b0;
    tick();
    clear_obs();
    do_start(NK, NIV);
    for (int i = 0; i < 4; i++) send(nc[i], 1'b0);
    wait_drained();
    check_nist("rerun");

    // start pulse during WAIT with another iv is ignored
    clear_obs();
    do_start(NK, NIV);
    send(nc[0], 1'b0);
    tick();
    key = NK; iv = AIV; start = 1'b1;
    tick();
    start = 1'b0; iv = NIV;
    for (int i = 1; i < 4; i++) send(nc[i], 1'b0);
    wait_drained();
    check_nist("ign_start");

    // in_valid held high: acceptances on alternate cycles
    clear_obs();
    do_start(NK, NIV);
    for (int i = 0; i < 4; i++) send(nc[i], 1'b1);
    in_valid = 1'b0;
    wait_drained();
    check_nist("cont");
    chk("cont_acc_count", 128'(acc_cyc.size()), 128'(4));
    for (int i = 1; i < acc_cyc.size(); i++)
      chk("cont_gap", 128'(acc_cyc[i] - acc_cyc[i-1]), 128'(2));
    chk("cont_blk_cnt", 128'(cnt_m), 128'(4));

    // Round trip through the 16-block instance
    rst = 1'b1; sel = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    fb = AIV;
    for (int i = 0; i < 16; i++) begin
      rp[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
      rc[i] = rp[i] ^ model_aes(NK, fb);
      fb    = rc[i];
    end
    clear_obs();
    do_start(NK, AIV);
    for (int i = 0; i < 16; i++) send(rc[i], 1'b0);
    wait_drained();
    chk("rt_count", 128'(obs.size()), 128'(16));
    for (int i = 0; i < 16 && i < obs.size(); i++) chk("rt_pt", obs[i], rp[i]);
    chk("rt_done_once", 128'(done_seen), 128'(1));
    chk("rt_blk_cnt", 128'(cnt_m), 128'(16));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cfb_d_stream.md
# cfb_d_stream

Streaming AES-128 CFB-128 decryptor, the receive-side counterpart of the CFB encryptor. Accepts a sequence of 128-bit ciphertext blocks over a valid/ready handshake and returns plaintext blocks in order. Internally it runs the existing combinational AES-128 forward-cipher core on a registered feedback value. It sits between the ciphertext source (file loader or bus) and the image sink, and decrypts streams produced by the CFB encryptor with the same key and IV.

## Interface
- NUM_BLOCKS, 65536: blocks per stream; range 1..65536.
- CNT_W, 17: counter width; must satisfy 2^CNT_W > NUM_BLOCKS.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse in IDLE; latches key and iv; ignored in any other state.
- key  in  [128:1]  AES-128 key; bit 128 is MSB.
- iv  in  [128:1]  initial feedback value.
- in_valid  in  1  ciphertext present.
- in_ready  out  1  block will accept ciphertext this cycle.
- ciphertext  in  [128:1]  ciphertext block.
- out_valid  out  1  plaintext register holds a block.
- out_ready  in  1  sink accepts plaintext.
- plaintext  out  [128:1]  decrypted block.
- blk_cnt  out  [CNT_W:1]  blocks accepted in the current stream.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle pulse when the last block is accepted.

## Operation
- Registers: key_r, fb_r, ks_r (keystream), pt_r, out_valid, blk_cnt, state.
- Decryption per block: P = C xor AES_K(fb); fb_next = C. The cipher always runs forward. There is no inverse cipher.
- FSM states:
  - IDLE: in_ready = 0. On start, key_r <= key, fb_r <= iv, blk_cnt <= 0, then go to GEN.
  - GEN (1 cycle): ks_r <= AES(key_r, fb_r), then go to WAIT.
  - WAIT: in_ready = !out_valid || out_ready. On in_valid && in_ready:
    - pt_r <= ciphertext ^ ks_r
    - fb_r <= ciphertext
    - out_valid <= 1
    - blk_cnt <= blk_cnt + 1
    - if blk_cnt + 1 == NUM_BLOCKS: done = 1 for that cycle and go to IDLE; otherwise go to GEN.
- Output handshake:
  - out_valid clears on out_ready when no new block is loaded in the same cycle.
  - A simultaneous drain and load keeps out_valid = 1 with the new data.
  - pt_r is held stable while out_valid && !out_ready.
- Returning to IDLE does not clear out_valid. The final block drains normally.
- A start pulse in IDLE while out_valid = 1 is legal. The pending output is unaffected.
- blk_cnt holds its final value in IDLE until the next start.
- Reset (asynchronous, any state, including mid-stream) clears:
  - state to IDLE
  - key_r, fb_r, ks_r, pt_r to 0
  - out_valid, blk_cnt, done to 0

  The interrupted stream is abandoned. A new start is required.
- Reset values of outputs: in_ready 0, out_valid 0, plaintext 0, blk_cnt 0, busy 0, done 0.

## Timing
- start at edge N: GEN in cycle N+1, WAIT (in_ready may be 1) in cycle N+2.
- Acceptance at edge M: out_valid = 1 and plaintext valid after M. The next acceptance is possible no earlier than edge M+2.
- Throughput: 1 block per 2 cycles. Latency: ciphertext accepted to plaintext visible is 1 cycle.
- ks_r is registered, so the AES combinational path goes only to ks_r, never to plaintext.
- done is asserted combinationally in the accepting cycle of block NUM_BLOCKS. busy drops on the following cycle.
- Backpressure: with out_ready = 0 and out_valid = 1, in_ready = 0 and the FSM stays in WAIT indefinitely.

## Test plan
- NIST SP800-38A CFB128, 4 blocks, free-running sink (out_ready = 1), NUM_BLOCKS = 4.
  - key = 2b7e151628aed2a6abf7158809cf4f3c, iv = 000102030405060708090a0b0c0d0e0f.
  - Ciphertexts in order:
    - 3b3fd92eb72dad20333449f8e83cfb4a
    - c8a64537a0b3a93fcde3cdad9f1ce58b
    - 26751f67a3cbb140b1808cf187a4f4df
    - c04b05357c5d1c0eeac4c66f9ff7f2e6
  - Required plaintexts in order:
    - 6bc1bee22e409f96e93d7e117393172a
    - ae2d8a571e03ac9c9eb76fac45af8e51
    - 30c81c46a35ce411e5fbc1191a0a52ef
    - f69f2445df4f9b17ad2b417be66c3710
  - done pulses once with blk_cnt = 4. busy = 0 afterwards.
- Same vectors with out_ready held 0 for 5 cycles after block 1.
  - plaintext stays 6bc1...172a and in_ready stays 0 throughout.
  - Remaining blocks are correct and none are dropped or duplicated.
- Round-trip: encrypt 16 random blocks with the CFB encryptor (key 2b7e..4f3c, iv 04c723c31896059a071280e2eb27b275), then feed them in with NUM_BLOCKS = 16 -> the original 16 blocks are recovered bit-exact.
- Assert rst after block 2 of the NIST stream.
  - Outputs read 0 immediately, asynchronously.
  - A fresh start with the same key/iv, fed from ciphertext block 1, reproduces the plaintext sequence.
- Pulse start during WAIT with a different iv -> ignored. fb_r is unchanged and the subsequent plaintext still matches NIST.
- in_valid held 1 continuously -> acceptances occur on alternate cycles only; blk_cnt increments by 1 per acceptance.
